// File: rtl/wbuf_pkg.sv
// wbuf_pkg: state encoding and sizing helpers shared by weight_buf_ctrl and its read FIFO.
package wbuf_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN} state_t;
    localparam int N_DELAY_DEF = 1;
    localparam int FIFO_DEPTH = N_DELAY_DEF + 1;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/wbuf_rd_fifo.sv
// wbuf_rd_fifo: small synchronous FIFO holding SRAM read returns until the PE array accepts them.
module wbuf_rd_fifo
    import wbuf_pkg::*;
#(
    parameter int DW = 128,
    parameter int DEPTH = 2,
    parameter int CW = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction
    always_comb begin
        wp_d  = push ? inc(wp_q) : wp_q;
        rp_d  = pop ? inc(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= din;
    end
    assign dout  = mem_q[rp_q];
    assign count = cnt_q;
    assign empty = cnt_q == '0;
endmodule

// File: rtl/weight_buf_ctrl.sv
// weight_buf_ctrl: sequences DMA loads into, and PE-array reads out of, one single-port weight SRAM.
// Define WBUF_ADDR_CHECK_EN to reject jobs whose base+len exceeds DEPTH and raise sticky err.
module weight_buf_ctrl
    import wbuf_pkg::*;
#(
    parameter int DW = 128,
    parameter int AW = 4,
    parameter int DEPTH = 16,
    parameter int N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_len,
    output logic          ld_done,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_base,
    input  logic [AW:0]   rd_len,
    output logic          rd_done,
    output logic          w_valid,
    input  logic          w_ready,
    output logic [DW-1:0] w_data,
    output logic          busy,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    output logic          err
);
    localparam int FD = N_DELAY + 1;
    localparam int FCW = cnt_w(FD);
    localparam int CW = cnt_w(2 * N_DELAY + 1);
    localparam logic [AW-1:0] A1 = 1;
    localparam logic [AW:0] L1 = 1;

    state_t state_q, state_d;
    logic [AW-1:0] ld_addr_q, ld_addr_d, rd_addr_q, rd_addr_d, pend_base_q, pend_base_d;
    logic [AW:0] ld_rem_q, ld_rem_d, rd_rem_q, rd_rem_d, out_rem_q, out_rem_d, pend_len_q, pend_len_d;
    logic pend_q, pend_d, ld_done_q, ld_done_d, rd_done_q, rd_done_d, err_q, err_d;
    logic [N_DELAY-1:0] vld_q, vld_d;
    logic wr, issue, rvalid, hs, push, pop, fifo_empty, ld_bad, rd_bad;
    logic [FCW-1:0] fifo_cnt;
    logic [DW-1:0] fifo_dout;
    logic [CW-1:0] inflight;
    logic [AW-1:0] rd_sel_base;
    logic [AW:0] rd_sel_len;

    assign rd_sel_base = pend_q ? pend_base_q : rd_base;
    assign rd_sel_len  = pend_q ? pend_len_q : rd_len;
`ifdef WBUF_ADDR_CHECK_EN
    assign ld_bad = ({1'b0, ld_base} + ld_len) > (AW + 1)'(DEPTH);
    assign rd_bad = ({1'b0, rd_sel_base} + rd_sel_len) > (AW + 1)'(DEPTH);
`else
    assign ld_bad = 1'b0;
    assign rd_bad = 1'b0;
`endif

    // Return path: vld_q tracks issued reads; an empty FIFO lets returning data bypass straight out.
    assign rvalid   = vld_q[N_DELAY-1];
    assign inflight = CW'($countones(vld_q));
    assign w_valid  = !fifo_empty || rvalid;
    assign w_data   = !fifo_empty ? fifo_dout : rvalid ? sram_rdata : '0;
    assign hs       = w_valid && w_ready;
    assign pop      = hs && !fifo_empty;
    assign push     = rvalid && !(fifo_empty && w_ready);
    assign wr       = state_q == S_LOAD && s_valid;
    assign issue    = state_q == S_READ && (inflight + CW'(fifo_cnt)) < CW'(FD);
    assign vld_d    = (vld_q << 1) | N_DELAY'(issue);

    always_comb begin
        state_d     = state_q;
        ld_addr_d   = ld_addr_q;
        ld_rem_d    = ld_rem_q;
        rd_addr_d   = rd_addr_q;
        rd_rem_d    = rd_rem_q;
        out_rem_d   = out_rem_q;
        pend_d      = pend_q;
        pend_base_d = pend_base_q;
        pend_len_d  = pend_len_q;
        err_d       = err_q;
        ld_done_d   = 1'b0;
        rd_done_d   = 1'b0;
        if (rd_start && !pend_q && ((state_q == S_IDLE && ld_start) || state_q == S_LOAD)) begin
            pend_d      = 1'b1;
            pend_base_d = rd_base;
            pend_len_d  = rd_len;
        end
        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    err_d = err_q || ld_bad;
                    if (ld_len == '0 || ld_bad) begin
                        ld_done_d = 1'b1;
                    end else begin
                        state_d   = S_LOAD;
                        ld_addr_d = ld_base;
                        ld_rem_d  = ld_len;
                    end
                end else if (rd_start || pend_q) begin
                    pend_d = 1'b0;
                    err_d  = err_q || rd_bad;
                    if (rd_sel_len == '0 || rd_bad) begin
                        rd_done_d = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        rd_addr_d = rd_sel_base;
                        rd_rem_d  = rd_sel_len;
                        out_rem_d = rd_sel_len;
                    end
                end
            end
            S_LOAD: begin
                if (wr) begin
                    ld_addr_d = ld_addr_q + A1;
                    ld_rem_d  = ld_rem_q - L1;
                    if (ld_rem_q == L1) begin
                        state_d   = S_IDLE;
                        ld_done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + A1;
                    rd_rem_d  = rd_rem_q - L1;
                    if (rd_rem_q == L1) state_d = S_DRAIN;
                end
            end
            default: ;
        endcase
        // The job ends on the final downstream handshake, by which point nothing is left in flight.
        if (hs) begin
            out_rem_d = out_rem_q - L1;
            if (out_rem_q == L1) begin
                state_d   = S_IDLE;
                rd_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ld_addr_q   <= '0;
            ld_rem_q    <= '0;
            rd_addr_q   <= '0;
            rd_rem_q    <= '0;
            out_rem_q   <= '0;
            pend_q      <= 1'b0;
            pend_base_q <= '0;
            pend_len_q  <= '0;
            err_q       <= 1'b0;
            ld_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            ld_addr_q   <= ld_addr_d;
            ld_rem_q    <= ld_rem_d;
            rd_addr_q   <= rd_addr_d;
            rd_rem_q    <= rd_rem_d;
            out_rem_q   <= out_rem_d;
            pend_q      <= pend_d;
            pend_base_q <= pend_base_d;
            pend_len_q  <= pend_len_d;
            err_q       <= err_d;
            ld_done_q   <= ld_done_d;
            rd_done_q   <= rd_done_d;
            vld_q       <= vld_d;
        end
    end

    wbuf_rd_fifo #(.DW(DW), .DEPTH(FD), .CW(FCW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sram_rdata),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );

    assign sram_cs    = wr || issue;
    assign sram_we    = wr;
    assign sram_addr  = wr ? ld_addr_q : issue ? rd_addr_q : '0;
    assign sram_wdata = wr ? s_data : '0;
    assign s_ready    = state_q == S_LOAD;
    assign busy       = state_q != S_IDLE || pend_q;
    assign ld_done    = ld_done_q;
    assign rd_done    = rd_done_q;
    assign err        = err_q;
endmodule
